// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: instruction decode, datapath selects/enables,
// memory-bus handshake, MULT/DIV stall hold, and halt on a jump to address 0.
module mips_mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        stall,
  input  logic        OUTLSB,
  input  logic        lessthan,
  input  logic        PcIs0,
  input  logic [31:0] memloc,
  input  logic        waitrequest,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic        active,
  output logic        PcEn,
  output logic        IorD,
  output logic        IrWrite,
  output logic        IrSel,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        ExtSel,
  output logic        ALUsel,
  output logic        PCSrc,
  output logic        is_jump,
  output logic        Link,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  MemExt,
  output logic [4:0]  ALUControl
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_RALU, C_IALU, C_LOAD, C_STORE, C_MULDIV, C_BEQNE, C_BZ, C_J, C_JR
  } cls_t;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_XOR = 5'd4, OP_SLT = 5'd5, OP_SLTU = 5'd6, OP_LUI = 5'd7,
                         OP_SLL = 5'd8, OP_SRL = 5'd9, OP_SRA = 5'd10, OP_EQ = 5'd11,
                         OP_NE = 5'd12, OP_MULT = 5'd13, OP_DIV = 5'd14, OP_JTGT = 5'd15;

  state_t state_q, state_d;
  // Set by reset, cleared when the first fetch completes: the fetch at PC=0
  // right after reset must not be mistaken for a jump to 0.
  logic   first_q, first_d;

  cls_t       cls;
  logic [4:0] alu_op;
  logic       ext_sel, is_link, br_taken;
  logic [1:0] mem_ext;
  logic [3:0] st_be;

  logic [5:0] opcode, funct;
  assign opcode = Instr[31:26];
  assign funct  = Instr[5:0];

  logic unused_bits;
  assign unused_bits = ^{Instr[25:21], Instr[15:6], memloc[31:2]};

  // Instruction decode into a class plus the ALU op and side selects
  always_comb begin
    cls     = C_NOP;
    alu_op  = OP_ADD;
    ext_sel = 1'b0;
    is_link = 1'b0;
    mem_ext = 2'b00;
    st_be   = 4'hF;
    case (opcode)
      6'h00: case (funct)
        6'h00, 6'h04: begin cls = C_RALU; alu_op = OP_SLL;  end
        6'h02, 6'h06: begin cls = C_RALU; alu_op = OP_SRL;  end
        6'h03, 6'h07: begin cls = C_RALU; alu_op = OP_SRA;  end
        6'h08:        cls = C_JR;
        6'h09:        begin cls = C_JR; is_link = 1'b1; end
        6'h18, 6'h19: begin cls = C_MULDIV; alu_op = OP_MULT; end
        6'h1A, 6'h1B: begin cls = C_MULDIV; alu_op = OP_DIV;  end
        6'h20, 6'h21: begin cls = C_RALU; alu_op = OP_ADD;  end
        6'h22, 6'h23: begin cls = C_RALU; alu_op = OP_SUB;  end
        6'h24:        begin cls = C_RALU; alu_op = OP_AND;  end
        6'h25:        begin cls = C_RALU; alu_op = OP_OR;   end
        6'h26:        begin cls = C_RALU; alu_op = OP_XOR;  end
        6'h2A:        begin cls = C_RALU; alu_op = OP_SLT;  end
        6'h2B:        begin cls = C_RALU; alu_op = OP_SLTU; end
        default:      cls = C_NOP;
      endcase
      6'h01: if (Instr[20:17] == 4'd0) cls = C_BZ;  // rt=0 BLTZ, rt=1 BGEZ
      6'h02: begin cls = C_J; alu_op = OP_JTGT; end
      6'h03: begin cls = C_J; alu_op = OP_JTGT; is_link = 1'b1; end
      6'h04: begin cls = C_BEQNE; alu_op = OP_EQ; end
      6'h05: begin cls = C_BEQNE; alu_op = OP_NE; end
      6'h08, 6'h09: begin cls = C_IALU; alu_op = OP_ADD;  end
      6'h0A: begin cls = C_IALU; alu_op = OP_SLT;  end
      6'h0B: begin cls = C_IALU; alu_op = OP_SLTU; end
      6'h0C: begin cls = C_IALU; alu_op = OP_AND; ext_sel = 1'b1; end
      6'h0D: begin cls = C_IALU; alu_op = OP_OR;  ext_sel = 1'b1; end
      6'h0E: begin cls = C_IALU; alu_op = OP_XOR; ext_sel = 1'b1; end
      6'h0F: begin cls = C_IALU; alu_op = OP_LUI; end
      6'h20: begin cls = C_LOAD; mem_ext = 2'b10; end
      6'h21: begin cls = C_LOAD; mem_ext = 2'b11; end
      6'h23: begin cls = C_LOAD; mem_ext = 2'b00; end
      6'h28: begin cls = C_STORE; st_be = 4'(4'b0001 << memloc[1:0]); end
      6'h29: begin cls = C_STORE; st_be = 4'(4'b0011 << memloc[1:0]); end
      6'h2B: begin cls = C_STORE; st_be = 4'hF; end
      default: cls = C_NOP;
    endcase
    // BEQ/BNE take the ALU compare bit; BLTZ/BGEZ take the registered sign test
    if (cls == C_BZ) br_taken = Instr[16] ? ~lessthan : lessthan;
    else             br_taken = OUTLSB;
  end

  // State and first-fetch flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Next state and all control outputs
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'h0;
    active     = (state_q != S_HALT);
    PcEn       = 1'b0;
    IorD       = 1'b0;
    IrWrite    = 1'b0;
    IrSel      = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ExtSel     = 1'b0;
    ALUsel     = 1'b0;
    PCSrc      = 1'b0;
    is_jump    = 1'b0;
    Link       = 1'b0;
    ALUSrcB    = 2'b00;
    MemExt     = 2'b00;
    ALUControl = OP_ADD;
    case (state_q)
      S_FETCH: begin
        if (PcIs0 && !first_q) begin
          state_d = S_HALT;  // no bus cycle is started for address 0
        end else begin
          read       = 1'b1;
          byteenable = 4'hF;
          if (!waitrequest) begin
            IrWrite = 1'b1;
            ALUSrcB = 2'b01;
            PcEn    = 1'b1;
            first_d = 1'b0;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        IrSel   = 1'b1;
        ALUSrcB = 2'b11;  // PC+4 + (imm<<2): branch target into aluout
        state_d = S_EXEC;
      end
      S_EXEC: begin
        IrSel      = 1'b1;
        ALUControl = alu_op;
        state_d    = S_FETCH;
        case (cls)
          C_RALU: begin ALUSrcA = 1'b1; state_d = S_WB; end
          C_IALU: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ExtSel = ext_sel; state_d = S_WB; end
          C_LOAD, C_STORE: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; state_d = S_MEM; end
          C_MULDIV: begin
            ALUSrcA = 1'b1;
            if (stall) state_d = S_EXEC;
          end
          C_BEQNE, C_BZ: begin ALUSrcA = 1'b1; ALUsel = 1'b1; state_d = S_BRANCH; end
          C_J: begin
            PcEn     = 1'b1;
            is_jump  = 1'b1;
            Link     = is_link;
            RegWrite = is_link;
            MemToReg = is_link;
          end
          C_JR: begin
            // rt is $0 for JR/JALR, so srcb=rt gives rs+0
            ALUSrcA  = 1'b1;
            PcEn     = 1'b1;
            is_jump  = 1'b1;
            Link     = is_link;
            RegWrite = is_link;
            MemToReg = is_link;
            RegDst   = is_link;
          end
          default: ;
        endcase
      end
      S_BRANCH: begin
        IrSel = 1'b1;
        if (br_taken) begin
          PCSrc   = 1'b1;
          PcEn    = 1'b1;
          is_jump = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_MEM: begin
        IrSel  = 1'b1;
        IorD   = 1'b1;
        ALUsel = 1'b1;
        if (cls == C_LOAD) begin
          read       = 1'b1;
          byteenable = 4'hF;
          MemExt     = mem_ext;
          RegWrite   = ~waitrequest;
        end else begin
          write      = 1'b1;
          byteenable = st_be;
        end
        if (!waitrequest) state_d = S_FETCH;
      end
      S_WB: begin
        IrSel    = 1'b1;
        ALUsel   = 1'b1;
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        RegDst   = (opcode == 6'h00);
        state_d  = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    // Reset cycle: everything quiet except active
    if (reset) begin
      state_d    = S_FETCH;
      first_d    = 1'b1;
      read       = 1'b0;
      write      = 1'b0;
      byteenable = 4'h0;
      active     = 1'b1;
      PcEn       = 1'b0;
      IorD       = 1'b0;
      IrWrite    = 1'b0;
      IrSel      = 1'b0;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ExtSel     = 1'b0;
      ALUsel     = 1'b0;
      PCSrc      = 1'b0;
      is_jump    = 1'b0;
      Link       = 1'b0;
      ALUSrcB    = 2'b00;
      MemExt     = 2'b00;
      ALUControl = OP_ADD;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed, table-driven bench for the multicycle MIPS controller.
module tb_mips_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        stall, OUTLSB, lessthan, PcIs0, waitrequest;
  logic [31:0] memloc;
  logic        read, write, active, PcEn, IorD, IrWrite, IrSel, RegDst, MemToReg, RegWrite;
  logic        ALUSrcA, ExtSel, ALUsel, PCSrc, is_jump, Link;
  logic [3:0]  byteenable;
  logic [1:0]  ALUSrcB, MemExt;
  logic [4:0]  ALUControl;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .stall(stall), .OUTLSB(OUTLSB),
    .lessthan(lessthan), .PcIs0(PcIs0), .memloc(memloc), .waitrequest(waitrequest),
    .read(read), .write(write), .byteenable(byteenable), .active(active), .PcEn(PcEn),
    .IorD(IorD), .IrWrite(IrWrite), .IrSel(IrSel), .RegDst(RegDst), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ExtSel(ExtSel), .ALUsel(ALUsel),
    .PCSrc(PCSrc), .is_jump(is_jump), .Link(Link), .ALUSrcB(ALUSrcB), .MemExt(MemExt),
    .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  // flag positions in the packed output word
  localparam int RD = 1 << 15, WR = 1 << 14, ACT = 1 << 13, PCEN = 1 << 12, IORD = 1 << 11,
                 IRW = 1 << 10, IRSEL = 1 << 9, RDST = 1 << 8, M2R = 1 << 7, RW = 1 << 6,
                 SRCA = 1 << 5, EXT = 1 << 4, ASEL = 1 << 3, PCS = 1 << 2, JMP = 1 << 1, LNK = 1;
  // input bundle {waitrequest, stall, OUTLSB, lessthan, PcIs0}
  localparam logic [4:0] NONE = 5'b00000, W = 5'b10000, S = 5'b01000, L = 5'b00100,
                         T = 5'b00010, Z = 5'b00001;

  localparam logic [31:0] ADDU = 32'h00221821, ORI  = 32'h342200FF, SB   = 32'hA0250003,
                          SH   = 32'hA4250002, BEQ  = 32'h10220004, BNE  = 32'h14220004,
                          BLTZ = 32'h04200004, BGEZ = 32'h04210004, JAL  = 32'h0C000040,
                          UNK  = 32'hFC000000, J    = 32'h08000040, LH   = 32'h84240002,
                          LW   = 32'h8C240010, MULT = 32'h00220018, JR   = 32'h03E00008;

  function automatic logic [28:0] mk(input int f, input logic [3:0] be, input logic [1:0] sb,
                                     input logic [1:0] me, input logic [4:0] ctl);
    return {f[15:0], be, sb, me, ctl};
  endfunction

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] instr;
    logic [4:0]  ci;
    logic [31:0] loc;
    logic [28:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0, nbad = 0, pcen_cnt = 0;

  logic [28:0] act_v;
  assign act_v = {read, write, active, PcEn, IorD, IrWrite, IrSel, RegDst, MemToReg, RegWrite,
                  ALUSrcA, ExtSel, ALUsel, PCSrc, is_jump, Link,
                  byteenable, ALUSrcB, MemExt, ALUControl};

  task automatic add(input string nm, input logic r, input logic [31:0] ins,
                     input logic [4:0] ci, input logic [31:0] loc, input logic [28:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.instr = ins; v.ci = ci; v.loc = loc; v.exp = e;
    tbl.push_back(v);
  endtask

  // drive one cycle of inputs, compare outputs mid-cycle, advance past the edge
  task automatic apply(input vec_t v);
    reset = v.rst;
    Instr = v.instr;
    {waitrequest, stall, OUTLSB, lessthan, PcIs0} = v.ci;
    memloc = v.loc;
    @(negedge clk);
    nvec++;
    if (act_v !== v.exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", v.name, act_v, v.exp);
    end
    pcen_cnt += int'(PcEn);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input logic r, input logic [31:0] ins,
                      input logic [4:0] ci, input logic [31:0] loc, input logic [28:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.instr = ins; v.ci = ci; v.loc = loc; v.exp = e;
    apply(v);
  endtask

  logic [28:0] RST, FOK, FWT, DEC, LSEX;

  initial begin
    RST  = mk(ACT, 4'h0, 2'b00, 2'b00, 5'd0);
    FOK  = mk(RD | ACT | PCEN | IRW, 4'hF, 2'b01, 2'b00, 5'd0);
    FWT  = mk(RD | ACT, 4'hF, 2'b00, 2'b00, 5'd0);
    DEC  = mk(ACT | IRSEL, 4'h0, 2'b11, 2'b00, 5'd0);
    LSEX = mk(ACT | IRSEL | SRCA, 4'h0, 2'b10, 2'b00, 5'd0);

    add("reset",       1, 32'h0, NONE, 0, RST);
    // ADDU: F D E W; first fetch at PC=0 must not halt
    add("addu_fetch",  0, ADDU, Z, 0, FOK);
    add("addu_dec",    0, ADDU, NONE, 0, DEC);
    add("addu_exec",   0, ADDU, NONE, 0, mk(ACT | IRSEL | SRCA, 4'h0, 2'b00, 2'b00, 5'd0));
    add("addu_wb",     0, ADDU, NONE, 0, mk(ACT | IRSEL | ASEL | M2R | RW | RDST, 4'h0, 2'b00, 2'b00, 5'd0));
    // ORI: zero-extended logical immediate
    add("ori_fetch",   0, ORI, NONE, 0, FOK);
    add("ori_dec",     0, ORI, NONE, 0, DEC);
    add("ori_exec",    0, ORI, NONE, 0, mk(ACT | IRSEL | SRCA | EXT, 4'h0, 2'b10, 2'b00, 5'd3));
    add("ori_wb",      0, ORI, NONE, 0, mk(ACT | IRSEL | ASEL | M2R | RW, 4'h0, 2'b00, 2'b00, 5'd0));
    // SB to 0x1003, with one fetch wait state
    add("sb_fwait",    0, SB, W, 0, FWT);
    add("sb_fetch",    0, SB, NONE, 0, FOK);
    add("sb_dec",      0, SB, NONE, 0, DEC);
    add("sb_exec",     0, SB, NONE, 0, LSEX);
    add("sb_mem",      0, SB, NONE, 32'h1003, mk(WR | ACT | IORD | IRSEL | ASEL, 4'b1000, 2'b00, 2'b00, 5'd0));
    // SH to 0x1002
    add("sh_fetch",    0, SH, NONE, 0, FOK);
    add("sh_dec",      0, SH, NONE, 0, DEC);
    add("sh_exec",     0, SH, NONE, 0, LSEX);
    add("sh_mem",      0, SH, NONE, 32'h1002, mk(WR | ACT | IORD | IRSEL | ASEL, 4'b1100, 2'b00, 2'b00, 5'd0));
    // BEQ taken, BNE not taken
    add("beq_fetch",   0, BEQ, NONE, 0, FOK);
    add("beq_dec",     0, BEQ, NONE, 0, DEC);
    add("beq_exec",    0, BEQ, NONE, 0, mk(ACT | IRSEL | SRCA | ASEL, 4'h0, 2'b00, 2'b00, 5'd11));
    add("beq_branch",  0, BEQ, L, 0, mk(ACT | IRSEL | PCS | PCEN | JMP, 4'h0, 2'b00, 2'b00, 5'd0));
    add("bne_fetch",   0, BNE, NONE, 0, FOK);
    add("bne_dec",     0, BNE, NONE, 0, DEC);
    add("bne_exec",    0, BNE, NONE, 0, mk(ACT | IRSEL | SRCA | ASEL, 4'h0, 2'b00, 2'b00, 5'd12));
    add("bne_branch",  0, BNE, NONE, 0, mk(ACT | IRSEL, 4'h0, 2'b00, 2'b00, 5'd0));
    // BLTZ with rs<0 taken; BGEZ with rs<0 not taken
    add("bltz_fetch",  0, BLTZ, NONE, 0, FOK);
    add("bltz_dec",    0, BLTZ, NONE, 0, DEC);
    add("bltz_exec",   0, BLTZ, NONE, 0, mk(ACT | IRSEL | SRCA | ASEL, 4'h0, 2'b00, 2'b00, 5'd0));
    add("bltz_branch", 0, BLTZ, T, 0, mk(ACT | IRSEL | PCS | PCEN | JMP, 4'h0, 2'b00, 2'b00, 5'd0));
    add("bgez_fetch",  0, BGEZ, NONE, 0, FOK);
    add("bgez_dec",    0, BGEZ, NONE, 0, DEC);
    add("bgez_exec",   0, BGEZ, NONE, 0, mk(ACT | IRSEL | SRCA | ASEL, 4'h0, 2'b00, 2'b00, 5'd0));
    add("bgez_branch", 0, BGEZ, T | L, 0, mk(ACT | IRSEL, 4'h0, 2'b00, 2'b00, 5'd0));
    // JAL: 3-cycle jump with link
    add("jal_fetch",   0, JAL, NONE, 0, FOK);
    add("jal_dec",     0, JAL, NONE, 0, DEC);
    add("jal_exec",    0, JAL, NONE, 0, mk(ACT | IRSEL | PCEN | JMP | LNK | RW | M2R, 4'h0, 2'b00, 2'b00, 5'd15));
    // unknown opcode behaves as NOP
    add("unk_fetch",   0, UNK, NONE, 0, FOK);
    add("unk_dec",     0, UNK, NONE, 0, DEC);
    add("unk_exec",    0, UNK, NONE, 0, mk(ACT | IRSEL, 4'h0, 2'b00, 2'b00, 5'd0));
    // J
    add("j_fetch",     0, J, NONE, 0, FOK);
    add("j_dec",       0, J, NONE, 0, DEC);
    add("j_exec",      0, J, NONE, 0, mk(ACT | IRSEL | PCEN | JMP, 4'h0, 2'b00, 2'b00, 5'd15));
    // LH: signed-half extension on completion
    add("lh_fetch",    0, LH, NONE, 0, FOK);
    add("lh_dec",      0, LH, NONE, 0, DEC);
    add("lh_exec",     0, LH, NONE, 0, LSEX);
    add("lh_mem",      0, LH, NONE, 32'h1002, mk(RD | ACT | IORD | IRSEL | ASEL | RW, 4'hF, 2'b00, 2'b11, 5'd0));

    foreach (tbl[i]) apply(tbl[i]);

    // LW with three MEM wait states: read held, RegWrite only on completion, one PcEn
    pcen_cnt = 0;
    step("lw_fetch", 0, LW, NONE, 0, FOK);
    step("lw_dec",   0, LW, NONE, 0, DEC);
    step("lw_exec",  0, LW, NONE, 0, LSEX);
    for (int k = 0; k < 3; k++)
      step("lw_mem_wait", 0, LW, W, 32'h1010, mk(RD | ACT | IORD | IRSEL | ASEL, 4'hF, 2'b00, 2'b00, 5'd0));
    step("lw_mem_done", 0, LW, NONE, 32'h1010, mk(RD | ACT | IORD | IRSEL | ASEL | RW, 4'hF, 2'b00, 2'b00, 5'd0));
    nvec++;
    if (pcen_cnt != 1) begin
      nbad++;
      $display("FAIL lw_pcen_count: got %0d want 1", pcen_cnt);
    end

    // MULT with stall high 10 cycles, then the cycle stall drops, then FETCH
    step("mult_fetch", 0, MULT, NONE, 0, FOK);
    step("mult_dec",   0, MULT, NONE, 0, DEC);
    for (int k = 0; k < 10; k++)
      step("mult_stall", 0, MULT, S, 0, mk(ACT | IRSEL | SRCA, 4'h0, 2'b00, 2'b00, 5'd13));
    step("mult_done",  0, MULT, NONE, 0, mk(ACT | IRSEL | SRCA, 4'h0, 2'b00, 2'b00, 5'd13));
    step("mult_next",  0, ADDU, NONE, 0, FOK);
    step("mult_nd",    0, ADDU, NONE, 0, DEC);
    step("mult_ne",    0, ADDU, NONE, 0, mk(ACT | IRSEL | SRCA, 4'h0, 2'b00, 2'b00, 5'd0));
    step("mult_nw",    0, ADDU, NONE, 0, mk(ACT | IRSEL | ASEL | M2R | RW | RDST, 4'h0, 2'b00, 2'b00, 5'd0));

    // JR to 0: next fetch sees PC==0 and halts
    step("jr_fetch",   0, JR, NONE, 0, FOK);
    step("jr_dec",     0, JR, NONE, 0, DEC);
    step("jr_exec",    0, JR, NONE, 0, mk(ACT | IRSEL | SRCA | PCEN | JMP, 4'h0, 2'b00, 2'b00, 5'd0));
    step("halt_fetch", 0, JR, Z, 0, mk(ACT, 4'h0, 2'b00, 2'b00, 5'd0));
    step("halt_1",     0, JR, Z, 0, mk(0, 4'h0, 2'b00, 2'b00, 5'd0));
    step("halt_2",     0, ADDU, Z, 0, mk(0, 4'h0, 2'b00, 2'b00, 5'd0));

    // reset out of HALT, then reset mid-MEM with waitrequest high
    step("rst_halt",   1, LW, Z, 0, RST);
    step("rl_fetch",   0, LW, Z, 0, FOK);
    step("rl_dec",     0, LW, NONE, 0, DEC);
    step("rl_exec",    0, LW, NONE, 0, LSEX);
    step("rl_mem",     0, LW, W, 32'h1010, mk(RD | ACT | IORD | IRSEL | ASEL, 4'hF, 2'b00, 2'b00, 5'd0));
    step("rst_mem",    1, LW, W, 32'h1010, RST);
    step("post_rst",   0, LW, Z, 0, FOK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control FSM for the MIPS CPU datapath. It decodes the instruction, drives every datapath select and enable, and sequences each instruction through fetch, decode, execute, memory and writeback. It also runs the memory-bus handshake (read/write/waitrequest), holds execute while the ALU reports a multi-cycle stall (MULT/DIV), and halts the core when execution reaches address 0.

## Interface
- No parameters. All outputs are registered state decodes or combinational decodes of state plus inputs; there are no internal datapath registers.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- Instr  in  32  current instruction from datapath (IR mux output).
- stall  in  1  ALU busy (MULT/DIV in progress).
- OUTLSB  in  1  bit 0 of registered ALU result; compare outcome.
- lessthan  in  1  registered rs < 0 (signed).
- PcIs0  in  1  PC == 0.
- memloc  in  32  current bus address; bits [1:0] are used for byteenable.
- waitrequest  in  1  bus stall; the current read/write stays asserted while high.
- read, write  out  1  bus strobes.
- byteenable  out  4  lane enables.
- active  out  1  core running.
- PcEn, IorD, IrWrite, IrSel, RegDst, MemToReg, RegWrite, ALUSrcA, ExtSel, ALUsel, PCSrc, is_jump, Link  out  1  datapath controls.
- ALUSrcB  out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2.
- MemExt  out  2  00 word, 10 signed byte, 11 signed half.
- ALUControl  out  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 LUI, 8 SLL, 9 SRL, 10 SRA, 11 EQ, 12 NE, 13 MULT, 14 DIV, 15 JTGT (jump target from instruction).

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT.
- FETCH
  - Drives IorD=0, read=1, byteenable=1111.
  - If PcIs0 is set on entry from any instruction other than the first after reset, go to HALT.
  - Hold while waitrequest=1.
  - On the cycle waitrequest=0: IrWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, ALUsel=0, PCSrc=0, PcEn=1 (PC<=PC+4). Go to DECODE.
- DECODE
  - IrSel=1 from here until the next FETCH.
  - ALUSrcA=0, ALUSrcB=11, ADD: the branch target is registered in aluout.
  - Go to EXEC.
- EXEC, by instruction class:
  - R-type ALU (funct select): ALUSrcA=1, ALUSrcB=00. Go to WB.
  - I-type ALU: ALUSrcA=1, ALUSrcB=10. ExtSel=1 for ANDI/ORI/XORI, else 0. Go to WB.
  - Load/store: ADD rs+signext(imm). Go to MEM.
  - MULT/DIV: hold EXEC while stall=1. Go to FETCH on the first cycle stall=0.
  - BEQ/BNE: ALUsel=1 so Brreg captures the target; ALUControl EQ/NE on rs,rt. Go to BRANCH.
  - BLTZ/BGEZ: compare uses lessthan. Go to BRANCH.
  - J/JAL: JTGT, ALUsel=0, PCSrc=0, PcEn=1, is_jump=1. JAL also sets Link=1, RegWrite=1 and writes PC (already +4) via MemToReg=1. Go to FETCH.
  - JR/JALR: srca=rs, ADD with srcb=0, PcEn=1, is_jump=1. JALR links to rd. Go to FETCH.
  - Unknown opcode: treated as NOP. Go to FETCH.
- BRANCH: if taken (OUTLSB=1, or lessthan per opcode), PCSrc=1, PcEn=1, is_jump=1. Go to FETCH.
- MEM
  - IorD=1, ALUsel=1. Loads assert read; stores assert write.
  - byteenable: SW 1111, SH 0011<<memloc[1:0], SB 0001<<memloc[1:0].
  - Hold while waitrequest=1.
  - Load completion (waitrequest=0): MemToReg=0, RegDst=0, RegWrite=1, MemExt per LW/LH/LB. Go to FETCH.
  - Store completion: go to FETCH.
- WB: ALUsel=1, MemToReg=1, RegWrite=1, RegDst=1 for R-type else 0. Go to FETCH.
- HALT: active=0, every strobe and enable 0. Leave only by reset.

## Timing
- Reset (synchronous): state<=FETCH, active=1. Every other output is 0 during the reset cycle; byteenable is 0000.
- Latency with zero wait states:
  - ALU: 4 cycles.
  - Load/store: 4 cycles.
  - Branch: 4 cycles.
  - Jump: 3 cycles.
  - MULT/DIV: 3 cycles plus the stall cycles.
- read and write are never asserted together. Each strobe stays high, with address and byteenable stable, until the cycle waitrequest=0.
- PcEn is high for exactly one cycle per completed PC update. A bus stall never produces a repeated increment.
- RegWrite and PcEn are never asserted in the same state, except JAL and JALR.
- reset asserted in any state, including mid-MEM with waitrequest=1: the next state is FETCH and the strobes drop in the reset cycle.
- The halt check uses PcIs0 only in FETCH. The first fetch after reset at PC=0 is exempt.

## Test plan
- Reset, then ADDU $3,$1,$2 with $1=5, $2=7, no waits -> states F,D,E,W; RegWrite in cycle 4; $3=12; PC+4.
- LW with waitrequest high for 3 cycles in MEM -> read held 4 cycles; RegWrite only in the completion cycle; PcEn pulses once in total.
- SB to address 0x1003 -> write=1, byteenable=1000. SH to 0x1002 -> byteenable=1100.
- BEQ taken (rs=rt=9, imm=4) -> PCSrc=1, PcEn=1 in BRANCH, is_jump=1. BNE on the same registers -> PcEn=0 in BRANCH.
- MULT with stall high for 10 cycles -> EXEC held 10 cycles, no PcEn or RegWrite in that time, then FETCH.
- JR to $ra=0 -> next FETCH sees PcIs0 -> HALT, active=0, no further read. Reset mid-MEM (waitrequest=1) -> read=0 next cycle, state FETCH.
